// File: rtl/risc_mem_io.sv
// Memory-mapped I/O for a 16-bit RISC core: 256x16 RAM, LED/switch ports, sticky bus error.
// Define RISC_MEM_IO_TIMER_EN to compile in the down-counting timer at 0xFF02-0xFF04.
module risc_mem_io (
  input  logic        clk,
  input  logic        reset,
  input  logic        mw_en,
  input  logic [15:0] addr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        timer_irq,
  output logic        bus_err
);

  localparam logic [15:0] ADDR_LED = 16'hFF00;
  localparam logic [15:0] ADDR_SW  = 16'hFF01;

  logic [15:0] mem_q [256];
  logic [15:0] led_q;
  logic [15:0] sw_meta_q;
  logic [15:0] sw_sync_q;
  logic        bus_err_q;
  logic        sel_ram;
  logic        mapped;

  assign sel_ram = (addr[15:8] == 8'h00);

  // NOTE: no reset branch here; RAM contents must survive reset and a clear would need a write sequencer.
  always_ff @(posedge clk) begin
    if (mw_en && sel_ram) mem_q[addr[7:0]] <= wr_data;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q     <= 16'h0000;
      sw_meta_q <= 16'h0000;
      sw_sync_q <= 16'h0000;
      bus_err_q <= 1'b0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      if (mw_en && (addr == ADDR_LED)) led_q <= wr_data;
      // Any edge that sees an unmapped address, read or write, is an error.
      if (!mapped) bus_err_q <= 1'b1;
    end
  end

`ifdef RISC_MEM_IO_TIMER_EN
  localparam logic [15:0] ADDR_CNT  = 16'hFF02;
  localparam logic [15:0] ADDR_CTRL = 16'hFF03;
  localparam logic [15:0] ADDR_RLD  = 16'hFF04;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} tmr_state_e;

  tmr_state_e  state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] reload_q, reload_d;
  logic        auto_q, auto_d;
  logic        expired_q, expired_d;
  logic        wr_ctrl, wr_rld, expire;

  assign wr_ctrl = mw_en && (addr == ADDR_CTRL);
  assign wr_rld  = mw_en && (addr == ADDR_RLD);
  assign expire  = (state_q == RUN) && (count_q == 16'h0000);
  assign mapped  = sel_ram || (addr inside {[ADDR_LED:ADDR_RLD]});

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    auto_d    = auto_q;
    expired_d = expired_q;
    if (state_q == RUN) begin
      if (count_q != 16'h0000) count_d = count_q - 16'h0001;
      else if (auto_q)         count_d = reload_q;
      else                     state_d = IDLE;
    end
    if (wr_rld) reload_d = wr_data;
    // A control write overrides the running sequence; disabling freezes the count.
    if (wr_ctrl) begin
      auto_d = wr_data[1];
      if (wr_data[15]) expired_d = 1'b0;
      if (wr_data[0]) begin
        state_d = RUN;
        count_d = reload_q;
      end else begin
        state_d = IDLE;
        count_d = count_q;
      end
    end
    if (expire) expired_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= 16'h0000;
      reload_q  <= 16'h0000;
      auto_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      auto_q    <= auto_d;
      expired_q <= expired_d;
    end
  end

  assign timer_irq = expired_q;
`else
  assign mapped    = sel_ram || (addr == ADDR_LED) || (addr == ADDR_SW);
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    // NOTE: rd_data is defaulted first so every path assigns it and no latch is inferred.
    rd_data = 16'h0000;
    if (sel_ram) begin
      rd_data = mem_q[addr[7:0]];
    end else begin
      case (addr)
        ADDR_LED:  rd_data = led_q;
        ADDR_SW:   rd_data = sw_sync_q;
`ifdef RISC_MEM_IO_TIMER_EN
        ADDR_CNT:  rd_data = count_q;
        ADDR_CTRL: rd_data = {expired_q, 13'h0000, auto_q, (state_q == RUN)};
        ADDR_RLD:  rd_data = reload_q;
`endif
        default:   rd_data = 16'h0000;
      endcase
    end
  end

  assign led     = led_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_risc_mem_io.sv
// Self-checking bench for risc_mem_io: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the address map.
module tb_risc_mem_io;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mw_en = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wr_data = 16'h0000;
  logic [15:0] sw = 16'h0000;
  logic [15:0] rd_data;
  logic [15:0] led;
  logic        timer_irq;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  risc_mem_io dut (
    .clk(clk), .reset(reset), .mw_en(mw_en), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .sw(sw), .led(led), .timer_irq(timer_irq), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Behavioural model of the memory map.
  logic [15:0] m_ram [256];
  bit          m_ok  [256];
  logic [15:0] m_led = '0;
  logic [15:0] m_sw1 = '0;
  logic [15:0] m_sw2 = '0;
  logic        m_bus_err = 1'b0;
`ifdef RISC_MEM_IO_TIMER_EN
  logic [15:0] m_cnt = '0;
  logic [15:0] m_rld = '0;
  logic        m_run = 1'b0;
  logic        m_auto = 1'b0;
  logic        m_exp = 1'b0;
`endif

  function automatic bit is_mapped(input logic [15:0] a);
    if (a <= 16'h00FF) return 1'b1;
    if (a == 16'hFF00 || a == 16'hFF01) return 1'b1;
`ifdef RISC_MEM_IO_TIMER_EN
    if (a >= 16'hFF02 && a <= 16'hFF04) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [15:0] exp_rd(input logic [15:0] a);
    if (a <= 16'h00FF) return m_ram[a[7:0]];
    case (a)
      16'hFF00: return m_led;
      16'hFF01: return m_sw2;
`ifdef RISC_MEM_IO_TIMER_EN
      16'hFF02: return m_cnt;
      16'hFF03: return {m_exp, 13'h0000, m_auto, m_run};
      16'hFF04: return m_rld;
`endif
      default:  return 16'h0000;
    endcase
  endfunction

  function automatic logic exp_irq();
`ifdef RISC_MEM_IO_TIMER_EN
    return m_exp;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_led <= '0; m_sw1 <= '0; m_sw2 <= '0; m_bus_err <= 1'b0;
`ifdef RISC_MEM_IO_TIMER_EN
      m_cnt <= '0; m_rld <= '0; m_run <= 1'b0; m_auto <= 1'b0; m_exp <= 1'b0;
`endif
    end else begin
      if (!is_mapped(addr)) m_bus_err <= 1'b1;
      if (mw_en && addr <= 16'h00FF) begin
        m_ram[addr[7:0]] <= wr_data;
        m_ok[addr[7:0]]  <= 1'b1;
      end
      if (mw_en && addr == 16'hFF00) m_led <= wr_data;
      m_sw1 <= sw;
      m_sw2 <= m_sw1;
`ifdef RISC_MEM_IO_TIMER_EN
      begin : tmr
        logic        fire;
        logic        nr;
        logic [15:0] nc;
        fire = m_run && (m_cnt == 16'h0000);
        nr = m_run;
        nc = m_cnt;
        if (m_run && m_cnt != 16'h0000) nc = m_cnt - 16'h0001;
        else if (fire && m_auto)        nc = m_rld;
        else if (fire)                  nr = 1'b0;
        if (mw_en && addr == 16'hFF03) begin
          m_auto <= wr_data[1];
          nr = wr_data[0];
          nc = wr_data[0] ? m_rld : m_cnt;
          if (wr_data[15] && !fire) m_exp <= 1'b0;
        end
        if (fire) m_exp <= 1'b1;
        if (mw_en && addr == 16'hFF04) m_rld <= wr_data;
        m_run <= nr;
        m_cnt <= nc;
      end
`endif
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, half a period away from the active edge.
  always @(negedge clk) begin
    if (addr > 16'h00FF || m_ok[addr[7:0]]) check("cmp rd_data", rd_data, exp_rd(addr));
    check("cmp led", led, m_led);
    check("cmp bus_err", {15'h0, bus_err}, {15'h0, m_bus_err});
    check("cmp timer_irq", {15'h0, timer_irq}, {15'h0, exp_irq()});
  end

  task automatic step(input logic w, input logic [15:0] a, input logic [15:0] d);
    mw_en = w; addr = a; wr_data = d;
    @(posedge clk);
    #2;
    mw_en = 1'b0;
  endtask

  task automatic peek(input logic [15:0] a);
    mw_en = 1'b0; addr = a;
    #1;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    check("reset led", led, 16'h0000);
    check("reset bus_err", {15'h0, bus_err}, 16'h0000);
    check("reset timer_irq", {15'h0, timer_irq}, 16'h0000);
    peek(16'hFF00); check("reset rd led", rd_data, 16'h0000);
    peek(16'hFF01); check("reset rd sw", rd_data, 16'h0000);
    @(posedge clk); #2 reset = 1'b1;

    // RAM write/read and untouched neighbour
    step(1'b1, 16'h0000, 16'h7777);
    step(1'b1, 16'h0011, 16'hCAFE);
    step(1'b1, 16'h0010, 16'h1234);
    peek(16'h0010); check("ram 0x0010", rd_data, 16'h1234);
    peek(16'h0011); check("ram 0x0011", rd_data, 16'hCAFE);

    // LED register
    check("led before write", led, 16'h0000);
    step(1'b1, 16'hFF00, 16'h00A5);
    check("led after write", led, 16'h00A5);
    peek(16'hFF00); check("rd led", rd_data, 16'h00A5);

    // Switch synchronizer latency
    sw = 16'hBEEF;
    peek(16'hFF01); check("sw cycle0", rd_data, 16'h0000);
    step(1'b0, 16'hFF01, 16'h0000); check("sw cycle1", rd_data, 16'h0000);
    step(1'b0, 16'hFF01, 16'h0000); check("sw cycle2", rd_data, 16'hBEEF);

    // Write to read-only switch register is ignored
    step(1'b1, 16'hFF01, 16'h1111);
    peek(16'hFF01); check("sw ro", rd_data, 16'hBEEF);
    check("led unaffected", led, 16'h00A5);
    check("no bus_err yet", {15'h0, bus_err}, 16'h0000);

`ifdef RISC_MEM_IO_TIMER_EN
    // One-shot: reload=3
    step(1'b1, 16'hFF04, 16'h0003);
    step(1'b1, 16'hFF03, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      peek(16'hFF02); check("oneshot count", rd_data, 16'(3 - i));
      check("oneshot irq low", {15'h0, timer_irq}, 16'h0000);
      step(1'b0, 16'hFF02, 16'h0000);
    end
    check("oneshot irq", {15'h0, timer_irq}, 16'h0001);
    peek(16'hFF03); check("oneshot ctrl", rd_data, 16'h8000);
    step(1'b1, 16'hFF03, 16'h8000);
    check("w1c clears", {15'h0, timer_irq}, 16'h0000);

    // Auto-reload: reload=2, period 3; clear-on-expiry loses to set
    step(1'b1, 16'hFF04, 16'h0002);
    step(1'b1, 16'hFF03, 16'h0003);
    step(1'b0, 16'hFF02, 16'h0000); check("auto E1", {15'h0, timer_irq}, 16'h0000);
    step(1'b0, 16'hFF02, 16'h0000); check("auto E2", {15'h0, timer_irq}, 16'h0000);
    step(1'b0, 16'hFF02, 16'h0000); check("auto E3", {15'h0, timer_irq}, 16'h0001);
    peek(16'hFF02); check("auto reloaded", rd_data, 16'h0002);
    step(1'b1, 16'hFF03, 16'h8003); check("auto restart clr", {15'h0, timer_irq}, 16'h0000);
    step(1'b0, 16'hFF02, 16'h0000);
    step(1'b0, 16'hFF02, 16'h0000); check("auto pre-expiry", {15'h0, timer_irq}, 16'h0000);
    step(1'b1, 16'hFF03, 16'h8000); check("set wins", {15'h0, timer_irq}, 16'h0001);
    peek(16'hFF03); check("set wins ctrl", rd_data, 16'h8000);
`endif

    // Unmapped write
    step(1'b1, 16'h0400, 16'h5555);
    check("unmapped bus_err", {15'h0, bus_err}, 16'h0001);
    peek(16'h0400); check("unmapped rd", rd_data, 16'h0000);
    peek(16'h0000); check("ram not aliased", rd_data, 16'h7777);

    // Reset: registers clear, RAM survives
    reset = 1'b0;
    #1;
    check("reset2 bus_err", {15'h0, bus_err}, 16'h0000);
    check("reset2 led", led, 16'h0000);
    peek(16'h0010); check("ram survives reset", rd_data, 16'h1234);
    @(posedge clk); #2 reset = 1'b1;

`ifdef RISC_MEM_IO_TIMER_EN
    // Reset mid-count aborts the timer
    step(1'b1, 16'hFF04, 16'h0007);
    step(1'b1, 16'hFF03, 16'h0001);
    step(1'b0, 16'hFF02, 16'h0000);
    step(1'b0, 16'hFF02, 16'h0000);
    peek(16'hFF02); check("midcount 5", rd_data, 16'h0005);
    reset = 1'b0;
    #1;
    check("abort count", rd_data, 16'h0000);
    check("abort irq", {15'h0, timer_irq}, 16'h0000);
    peek(16'hFF03); check("abort ctrl", rd_data, 16'h0000);
    @(posedge clk); #2 reset = 1'b1;
    repeat (3) step(1'b0, 16'hFF03, 16'h0000);
    check("stays idle", rd_data, 16'h0000);
    peek(16'hFF02); check("count held 0", rd_data, 16'h0000);
`else
    peek(16'hFF02); check("no timer rd", rd_data, 16'h0000);
    step(1'b0, 16'hFF02, 16'h0000);
    check("no timer bus_err", {15'h0, bus_err}, 16'h0001);
    check("no timer irq", {15'h0, timer_irq}, 16'h0000);
`endif

    // Randomized traffic; the negedge process compares against the model.
    for (int n = 0; n < 600; n++) begin
      logic [15:0] a;
      logic [15:0] d;
      int k;
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2, 3, 4: a = 16'($urandom_range(0, 31));
        5:             a = 16'hFF00;
        6:             a = 16'hFF01;
        7, 9:          a = 16'($urandom_range(16'hFF02, 16'hFF04));
        default:       a = 16'($urandom_range(16'h0100, 16'hFEFF));
      endcase
      d = (a == 16'hFF04) ? 16'($urandom_range(0, 6)) : 16'($urandom);
      sw = 16'($urandom);
      mw_en = 1'($urandom_range(0, 1));
      addr = a;
      wr_data = d;
      if ($urandom_range(0, 99) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
      @(posedge clk);
      #2;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_mem_io.md
RISC_MEM_IO -- requirements
Module: risc_mem_io

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; every register updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset; 0 forces reset state immediately regardless of clk.
REQ-003 SHALL have port mw_en, input, 1, memory write enable from processor.
REQ-004 SHALL have port addr, input, 16, word address from processor.
REQ-005 SHALL have port wr_data, input, 16, write data from processor.
REQ-006 SHALL have port rd_data, output, 16, read data to processor D_in.
REQ-007 SHALL have port sw, input, 16, asynchronous board switches.
REQ-008 SHALL have port led, output, 16, registered LED output port.
REQ-009 SHALL have port timer_irq, output, 1, level copy of timer expired flag.
REQ-010 SHALL have port bus_err, output, 1, sticky flag for any access to an unmapped address.

Function
REQ-011 Address map SHALL be: 0x0000-0x00FF RAM (256x16); 0xFF00 LED reg (R/W); 0xFF01 switch reg (R); 0xFF02 timer count (R); 0xFF03 timer ctrl/status (R/W); 0xFF04 timer reload (R/W); all others unmapped.
REQ-012 Reads SHALL be combinational from addr; unmapped reads SHALL return 0x0000.
REQ-013 Writes SHALL occur on the clk edge where mw_en=1; writes to read-only or unmapped addresses SHALL be ignored.
REQ-014 sw SHALL pass a 2-flop synchronizer; 0xFF01 returns the second flop (2-cycle latency).
REQ-015 bus_err SHALL set on any clk edge with addr unmapped and mw_en=1, or unmapped read selected by addr while mw_en=0 on the same edge; cleared only by reset.
REQ-016 Ctrl 0xFF03 bits: [0] enable, [1] auto_reload, [15] expired (write 1 to clear), others read 0.
REQ-017 Timer FSM SHALL have states IDLE and RUN; ctrl[0] reads 1 exactly in RUN.
REQ-018 Write to 0xFF03 with bit0=1 SHALL load count<=reload and enter RUN next cycle (restarts if already RUN).
REQ-019 Write to 0xFF03 with bit0=0 SHALL enter IDLE; count holds.
REQ-020 In RUN, count SHALL decrement by 1 per cycle while nonzero.
REQ-021 In RUN with count==0: expired<=1; if auto_reload then count<=reload, stay RUN; else enter IDLE.
REQ-022 Reload value 0 with auto_reload SHALL expire every cycle.
REQ-023 Writes to 0xFF04 during RUN SHALL take effect only at next load/reload.
REQ-024 Simultaneous expiry and write-1-to-clear of bit15 SHALL leave expired=1 (set wins).
REQ-025 timer_irq SHALL equal expired.

Reset
REQ-026 On reset=0: rd_data follows map with cleared regs; led=0x0000, sync flops=0, count=0, reload=0, ctrl=0x0000, state=IDLE, timer_irq=0, bus_err=0.
REQ-027 RAM contents SHALL NOT be cleared by reset.
REQ-028 Reset asserted mid-count SHALL abort the timer; after release it stays IDLE until software enables it.

Configuration
REQ-029 Macro RISC_MEM_IO_TIMER_EN SHALL compile in the timer (REQ-016..REQ-025).
REQ-030 Without RISC_MEM_IO_TIMER_EN: 0xFF02-0xFF04 SHALL be unmapped (read 0x0000, set bus_err), timer_irq tied 0, no timer registers synthesized.

Verification
REQ-031 Write 0x1234 to 0x0010, read 0x0010 -> rd_data=0x1234; read 0x0011 untouched -> prior value.
REQ-032 Write 0x00A5 to 0xFF00 -> led=0x00A5 after edge; sw=0xBEEF -> 0xFF01 reads 0xBEEF on 2nd cycle, not 1st.
REQ-033 reload=3, ctrl=0x0001 -> count 3,2,1,0, expired and timer_irq=1 on 5th cycle after write, ctrl[0]=0.
REQ-034 reload=2, ctrl=0x0003 -> expired every 3 cycles; write 0x8000 to 0xFF03 on an expiry cycle -> expired stays 1.
REQ-035 Write 0x5555 to 0x0400 -> bus_err=1, rd_data=0x0000 at 0x0400, RAM unchanged.
REQ-036 Pull reset=0 mid-count (count=5) without clk edge -> count=0, IDLE, timer_irq=0 immediately; with macro undefined, read 0xFF02 -> 0x0000, bus_err=1.
